atm_transaction: RTL and testbench

- Session/transaction controller directly downstream of the card-handling stage.
- Consumes the card-handling stage's authenticated `balance` and `wrong_psw`.
- Executes inquiry, deposit and withdraw requests from the ATM front panel.
- Returns `updated_balance` and a one-cycle `op_done` to card handling, which commits the value to the balance database. Also handles failed-PIN lockout, idle timeout and card ejection.

---
 rtl/atm_transaction.sv | 204 ++++++++++++++++++++
 tb/tb_atm_transaction.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_transaction.sv
// Session/transaction controller downstream of card handling: PIN lockout, inquiry/deposit/
// withdraw execution, idle timeout and card ejection, with a registered balance write-back.
module atm_transaction #(
  parameter int balance_width  = 20,
  parameter int max_withdraw   = 5000,
  parameter int max_attempts   = 3,
  parameter int timeout_cycles = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     card_in,
  input  logic                     wrong_psw,
  input  logic [balance_width-1:0] balance,
  input  logic                     op_valid,
  input  logic [1:0]               op_code,
  input  logic [balance_width-1:0] amount,
  output logic                     op_ready,
  output logic                     op_done,
  output logic [balance_width-1:0] updated_balance,
  output logic [1:0]               err_code,
  output logic                     auth_fail,
  output logic                     eject,
  output logic                     card_retained
);

  localparam int att_w = $clog2(max_attempts + 1);
  localparam int tmo_w = $clog2(timeout_cycles + 1);

  localparam logic [balance_width-1:0] max_wd   = balance_width'(max_withdraw);
  localparam logic [att_w-1:0]         att_last = att_w'(max_attempts - 1);
  localparam logic [tmo_w-1:0]         tmo_last = tmo_w'(timeout_cycles - 1);

  localparam logic [1:0] op_inquiry  = 2'b00;
  localparam logic [1:0] op_deposit  = 2'b01;
  localparam logic [1:0] op_withdraw = 2'b10;
  localparam logic [1:0] op_end      = 2'b11;

  localparam logic [1:0] err_ok        = 2'b00;
  localparam logic [1:0] err_funds     = 2'b01;
  localparam logic [1:0] err_limit     = 2'b10;
  localparam logic [1:0] err_overflow  = 2'b11;

  typedef enum logic [2:0] {
    s_idle,
    s_auth,
    s_ready,
    s_exec,
    s_done,
    s_eject,
    s_retain
  } state_t;

  state_t                   state;
  logic [att_w-1:0]         attempts;
  logic [tmo_w-1:0]         idle_cnt;
  logic [1:0]               cap_op;
  logic [balance_width-1:0] cap_amount;
  logic [balance_width-1:0] cap_balance;
  logic [balance_width-1:0] result;
  logic [1:0]               result_err;

  logic [balance_width:0]   dep_sum;
  logic [balance_width-1:0] exec_result;
  logic [1:0]               exec_err;

  // Arithmetic on the captured operands; a rejected operation leaves the balance untouched.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    exec_result = cap_balance;
    exec_err    = err_ok;
    dep_sum     = {1'b0, cap_balance} + {1'b0, cap_amount};
    case (cap_op)
      op_inquiry: ;
      op_deposit: begin
        if (dep_sum[balance_width]) exec_err = err_overflow;
        else                        exec_result = dep_sum[balance_width-1:0];
      end
      op_withdraw: begin
        if (cap_amount > max_wd)           exec_err = err_limit;
        else if (cap_amount > cap_balance) exec_err = err_funds;
        else                               exec_result = cap_balance - cap_amount;
      end
      default: ;
    endcase
  end

  // NOTE: all state and outputs use non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= s_idle;
      attempts        <= '0;
      idle_cnt        <= '0;
      cap_op          <= op_inquiry;
      cap_amount      <= '0;
      cap_balance     <= '0;
      result          <= '0;
      result_err      <= err_ok;
      op_ready        <= 1'b0;
      op_done         <= 1'b0;
      updated_balance <= '0;
      err_code        <= err_ok;
      auth_fail       <= 1'b0;
      eject           <= 1'b0;
      card_retained   <= 1'b0;
    end else begin
      op_done         <= 1'b0;
      auth_fail       <= 1'b0;
      updated_balance <= balance;

      case (state)
        s_idle: begin
          attempts      <= '0;
          idle_cnt      <= '0;
          op_ready      <= 1'b0;
          eject         <= 1'b0;
          card_retained <= 1'b0;
          if (card_in) state <= s_auth;
        end

        s_auth: begin
          if (!card_in) begin
            state <= s_idle;
          end else if (!wrong_psw) begin
            state    <= s_ready;
            attempts <= '0;
            idle_cnt <= '0;
            op_ready <= 1'b1;
          end else begin
            auth_fail <= 1'b1;
            attempts  <= attempts + att_w'(1);
            if (attempts == att_last) begin
              state         <= s_retain;
              card_retained <= 1'b1;
            end
          end
        end

        s_ready: begin
          if (!card_in) begin
            state    <= s_idle;
            op_ready <= 1'b0;
          end else if (op_valid && op_ready) begin
            op_ready <= 1'b0;
            idle_cnt <= '0;
            err_code <= err_ok;
            if (op_code == op_end) begin
              state <= s_eject;
              eject <= 1'b1;
            end else begin
              state       <= s_exec;
              cap_op      <= op_code;
              cap_amount  <= amount;
              cap_balance <= balance;
            end
          end else if (idle_cnt == tmo_last) begin
            state    <= s_eject;
            eject    <= 1'b1;
            op_ready <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + tmo_w'(1);
          end
        end

        s_exec: begin
          result     <= exec_result;
          result_err <= exec_err;
          state      <= s_done;
        end

        // The commit happens even if the card left during the operation.
        s_done: begin
          op_done         <= 1'b1;
          updated_balance <= result;
          err_code        <= result_err;
          if (card_in) begin
            state    <= s_ready;
            op_ready <= 1'b1;
            idle_cnt <= '0;
          end else begin
            state <= s_idle;
          end
        end

        s_eject: begin
          if (!card_in) begin
            state <= s_idle;
            eject <= 1'b0;
          end
        end

        s_retain: begin
          if (!card_in) begin
            state         <= s_idle;
            card_retained <= 1'b0;
          end
        end

        default: state <= s_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_transaction.sv
// Bench for atm_transaction: directed vector table, multi-cycle corner sequences and
// randomized operations checked against an arithmetic reference model.
module tb_atm_transaction;

  localparam int W      = 20;
  localparam int MAX_WD = 5000;
  localparam int TMO    = 1000;

  logic         clk = 1'b0;
  logic         rst;
  logic         card_in;
  logic         wrong_psw;
  logic [W-1:0] balance;
  logic         op_valid;
  logic [1:0]   op_code;
  logic [W-1:0] amount;
  logic         op_ready;
  logic         op_done;
  logic [W-1:0] updated_balance;
  logic [1:0]   err_code;
  logic         auth_fail;
  logic         eject;
  logic         card_retained;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  atm_transaction dut (
    .clk             (clk),
    .rst             (rst),
    .card_in         (card_in),
    .wrong_psw       (wrong_psw),
    .balance         (balance),
    .op_valid        (op_valid),
    .op_code         (op_code),
    .amount          (amount),
    .op_ready        (op_ready),
    .op_done         (op_done),
    .updated_balance (updated_balance),
    .err_code        (err_code),
    .auth_fail       (auth_fail),
    .eject           (eject),
    .card_retained   (card_retained)
  );

  typedef struct {
    logic [1:0]   code;
    logic [W-1:0] bal;
    logic [W-1:0] amt;
    logic [W-1:0] exp_res;
    logic [1:0]   exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: plain arithmetic on the operation rules.
  task automatic ref_op(input logic [1:0] code, input logic [W-1:0] bal, input logic [W-1:0] amt,
                        output logic [W-1:0] res, output logic [1:0] err);
    longint b;
    longint a;
    b   = bal;
    a   = amt;
    res = bal;
    err = 2'd0;
    if (code == 2'd1) begin
      if (b + a > (longint'(1) << W) - 1) err = 2'd3;
      else                                res = W'(b + a);
    end else if (code == 2'd2) begin
      if (a > MAX_WD)  err = 2'd2;
      else if (a > b)  err = 2'd1;
      else             res = W'(b - a);
    end
  endtask

  task automatic start_session(input logic [W-1:0] bal, output bit ok);
    int waited;
    waited    = 0;
    balance   = bal;
    wrong_psw = 1'b0;
    card_in   = 1'b1;
    step(1);
    while (!op_ready && waited < 10) begin
      step(1);
      waited++;
    end
    ok = op_ready;
  endtask

  task automatic end_session();
    card_in  = 1'b0;
    op_valid = 1'b0;
    step(3);
  endtask

  // Issues one operation and watches six cycles after the accepting edge.
  task automatic do_op(input logic [1:0] code, input logic [W-1:0] bal, input logic [W-1:0] amt,
                       output int lat, output int pulses,
                       output logic [W-1:0] res, output logic [1:0] err);
    int waited;
    waited = 0;
    while (!op_ready && waited < 20) begin
      step(1);
      waited++;
    end
    balance  = bal;
    op_code  = code;
    amount   = amt;
    op_valid = 1'b1;
    step(1);
    op_valid = 1'b0;
    lat      = -1;
    pulses   = 0;
    res      = '0;
    err      = '0;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      if (op_done) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          res = updated_balance;
          err = err_code;
        end
      end
    end
  endtask

  initial begin
    bit           ok;
    int           lat;
    int           pulses;
    int           fails;
    logic [W-1:0] res;
    logic [1:0]   err;
    logic [1:0]   rc;
    logic [W-1:0] rb;
    logic [W-1:0] ra;
    logic [W-1:0] exp_res;
    logic [1:0]   exp_err;

    vecs[0]  = '{2'd0, 20'd1000,   20'd0,    20'd1000,   2'd0};
    vecs[1]  = '{2'd2, 20'd1000,   20'd400,  20'd600,    2'd0};
    vecs[2]  = '{2'd2, 20'd1000,   20'd1200, 20'd1000,   2'd1};
    vecs[3]  = '{2'd2, 20'd9000,   20'd6000, 20'd9000,   2'd2};
    vecs[4]  = '{2'd1, 20'hFFFF0,  20'h20,   20'hFFFF0,  2'd3};
    vecs[5]  = '{2'd1, 20'hFFFF0,  20'h0F,   20'hFFFFF,  2'd0};
    vecs[6]  = '{2'd2, 20'd5000,   20'd5000, 20'd0,      2'd0};
    vecs[7]  = '{2'd2, 20'd9000,   20'd5001, 20'd9000,   2'd2};
    vecs[8]  = '{2'd2, 20'd100,    20'd6000, 20'd100,    2'd2};
    vecs[9]  = '{2'd1, 20'd123,    20'd0,    20'd123,    2'd0};
    vecs[10] = '{2'd2, 20'd77,     20'd0,    20'd77,     2'd0};
    vecs[11] = '{2'd1, 20'hFFFFF,  20'd1,    20'hFFFFF,  2'd3};
    vecs[12] = '{2'd1, 20'hFFFFE,  20'd1,    20'hFFFFF,  2'd0};
    vecs[13] = '{2'd0, 20'd4242,   20'd999,  20'd4242,   2'd0};

    rst       = 1'b1;
    card_in   = 1'b0;
    wrong_psw = 1'b0;
    balance   = 20'd1000;
    op_valid  = 1'b0;
    op_code   = 2'd0;
    amount    = '0;
    #3;
    check("rst_op_ready", 32'(op_ready), 0);
    check("rst_op_done", 32'(op_done), 0);
    check("rst_updated_balance", 32'(updated_balance), 0);
    check("rst_err_code", 32'(err_code), 0);
    check("rst_auth_fail", 32'(auth_fail), 0);
    check("rst_eject", 32'(eject), 0);
    check("rst_card_retained", 32'(card_retained), 0);
    step(2);
    rst = 1'b0;
    step(1);

    // Directed vector table, all in one session.
    start_session(20'd1000, ok);
    check("session_ready", 32'(ok), 1);
    for (int i = 0; i < 14; i++) begin
      do_op(vecs[i].code, vecs[i].bal, vecs[i].amt, lat, pulses, res, err);
      check("vec_latency", lat, 2);
      check("vec_pulses", pulses, 1);
      check("vec_result", 32'(res), 32'(vecs[i].exp_res));
      check("vec_err", 32'(err), 32'(vecs[i].exp_err));
      check("vec_err_hold", 32'(err_code), 32'(vecs[i].exp_err));
    end

    // updated_balance follows balance while no result is being committed.
    balance = 20'd777;
    step(1);
    check("reload_balance", 32'(updated_balance), 777);

    // Randomized operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      rc = 2'($urandom_range(0, 2));
      rb = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 20000)) : W'($urandom);
      case ($urandom_range(0, 3))
        0:       ra = W'($urandom_range(0, MAX_WD + 10));
        1:       ra = rb;
        2:       ra = W'($urandom);
        default: ra = W'(((1 << W) - 1) - int'(rb) + int'($urandom_range(0, 2)));
      endcase
      ref_op(rc, rb, ra, exp_res, exp_err);
      do_op(rc, rb, ra, lat, pulses, res, err);
      check("rand_latency", lat, 2);
      check("rand_pulses", pulses, 1);
      check("rand_result", 32'(res), 32'(exp_res));
      check("rand_err", 32'(err), 32'(exp_err));
    end
    end_session();

    // Lockout: three wrong PINs retain the card; op_valid meanwhile is ignored.
    card_in   = 1'b1;
    wrong_psw = 1'b1;
    op_valid  = 1'b1;
    op_code   = 2'd0;
    fails     = 0;
    pulses    = 0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (auth_fail) fails++;
      if (op_done) pulses++;
    end
    check("lock_auth_fail_count", fails, 3);
    check("lock_retained", 32'(card_retained), 1);
    check("lock_op_ready", 32'(op_ready), 0);
    check("lock_no_op_done", pulses, 0);
    op_valid = 1'b0;
    card_in  = 1'b0;
    step(1);
    check("lock_release", 32'(card_retained), 0);
    step(2);

    // Attempts start fresh in a new session: two wrong PINs then correct reaches READY.
    card_in   = 1'b1;
    wrong_psw = 1'b1;
    fails     = 0;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      if (auth_fail) fails++;
      if (k == 3) wrong_psw = 1'b0;
    end
    check("retry_auth_fail_count", fails, 2);
    check("retry_ready", 32'(op_ready), 1);
    check("retry_not_retained", 32'(card_retained), 0);
    end_session();

    // Idle timeout: eject after exactly TMO idle cycles in READY.
    start_session(20'd1000, ok);
    check("tmo_session_ready", 32'(ok), 1);
    step(TMO - 1);
    check("tmo_not_yet", 32'(eject), 0);
    check("tmo_still_ready", 32'(op_ready), 1);
    step(1);
    check("tmo_eject", 32'(eject), 1);
    check("tmo_op_ready_low", 32'(op_ready), 0);
    card_in = 1'b0;
    step(1);
    check("tmo_eject_release", 32'(eject), 0);
    step(2);

    // End-session request ejects on the next cycle; requests during EJECT are ignored.
    start_session(20'd500, ok);
    op_code  = 2'd3;
    op_valid = 1'b1;
    step(1);
    op_code = 2'd0;
    check("end_eject", 32'(eject), 1);
    check("end_op_ready_low", 32'(op_ready), 0);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step(1);
      if (op_done) pulses++;
    end
    check("end_no_op_done", pulses, 0);
    check("end_eject_held", 32'(eject), 1);
    card_in  = 1'b0;
    op_valid = 1'b0;
    step(1);
    check("end_eject_release", 32'(eject), 0);
    step(1);
    check("end_idle_not_ready", 32'(op_ready), 0);

    // Card removed during EXEC (d=0) or DONE (d=1): the operation still commits once.
    for (int d = 0; d < 2; d++) begin
      start_session(20'd1000, ok);
      balance  = 20'd1000;
      op_code  = 2'd1;
      amount   = 20'd50;
      op_valid = 1'b1;
      step(1);
      op_valid = 1'b0;
      if (d == 1) step(1);
      card_in = 1'b0;
      pulses  = 0;
      res     = '0;
      for (int k = 0; k < 6; k++) begin
        step(1);
        if (op_done) begin
          pulses++;
          res = updated_balance;
        end
      end
      check("pull_op_done_once", pulses, 1);
      check("pull_result", 32'(res), 1050);
      check("pull_idle", 32'(op_ready), 0);
      end_session();
    end

    // Card removed in READY together with a request: no operation.
    start_session(20'd1000, ok);
    card_in  = 1'b0;
    op_valid = 1'b1;
    op_code  = 2'd2;
    amount   = 20'd10;
    pulses   = 0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      if (op_done) pulses++;
    end
    check("ready_pull_no_op_done", pulses, 0);
    end_session();

    // Asynchronous reset during EXEC clears outputs without a clock edge.
    start_session(20'd1000, ok);
    do_op(2'd2, 20'd1000, 20'd2000, lat, pulses, res, err);
    check("pre_rst_err", 32'(err_code), 1);
    balance  = 20'd1000;
    op_code  = 2'd2;
    amount   = 20'd100;
    op_valid = 1'b1;
    step(1);
    op_valid = 1'b0;
    check("exec_op_ready_low", 32'(op_ready), 0);
    #2 rst = 1'b1;
    #1;
    check("arst_updated_balance", 32'(updated_balance), 0);
    check("arst_err_code", 32'(err_code), 0);
    check("arst_op_done", 32'(op_done), 0);
    check("arst_op_ready", 32'(op_ready), 0);
    card_in = 1'b0;
    step(1);
    rst    = 1'b0;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      if (op_done) pulses++;
    end
    check("arst_no_op_done", pulses, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
